// File: rtl/ram_ctrl_pkg.sv
// Shared encodings and widths for the 32x4 RAM scan controller.
// Op codes match the command port; state order is also the reset/idle-first encoding.
package ram_ctrl_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 4;
    localparam int SUM_W  = 9;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_FILL  = 2'b10,
        OP_SUM   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_CAP,
        FILL,
        SUM_RUN,
        SUM_DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/ram32x4.sv
// 32x4 single-port RAM with registered address/data/wren; q appears one cycle after the address edge.
// Contents are deliberately not reset, so an aborted sweep leaves partial data behind.
module ram32x4 #(
    parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
    parameter int DATA_W = ram_ctrl_pkg::DATA_W
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (wren) begin
            r_mem[address] <= data;
        end
        q <= r_mem[address];
    end

endmodule

// File: rtl/ram_addr_counter.sv
// Address sweep counter shared by FILL and SUM; clear has priority over enable.
// One-cycle registered update, no backpressure; o_last is combinational on the all-ones count.
module ram_addr_counter #(
    parameter int W = ram_ctrl_pkg::ADDR_W
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic         i_clear,
    input  logic         i_enable,
    output logic [W-1:0] o_count,
    output logic         o_last
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = &r_count;

endmodule

// File: rtl/ram_scan_ctrl.sv
// Command FSM driving an external 32x4 RAM: single write/read, full fill, and full-array sum.
// go is only sampled in IDLE; WRITE/READ/FILL/SUM finish with done 2/3/33/34 cycles after go.
module ram_scan_ctrl #(
    parameter int ADDR_W = ram_ctrl_pkg::ADDR_W,
    parameter int DATA_W = ram_ctrl_pkg::DATA_W
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          go,
    input  logic [1:0]                    op,
    input  logic [ADDR_W-1:0]             addr_in,
    input  logic [DATA_W-1:0]             data_in,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             rd_data,
    output logic [ram_ctrl_pkg::SUM_W-1:0] sum,
    output logic [ADDR_W-1:0]             ram_address,
    output logic [DATA_W-1:0]             ram_data,
    output logic                          ram_wren,
    input  logic [DATA_W-1:0]             ram_q
);

    import ram_ctrl_pkg::*;

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rd_data;
    logic [SUM_W-1:0]  r_acc;
    logic [SUM_W-1:0]  r_sum;
    logic [SUM_W-1:0]  w_acc_next;
    logic [ADDR_W-1:0] w_cnt;
    logic              w_last;
    logic              w_cnt_clr;
    logic              w_cnt_en;

    ram_addr_counter #(.W(ADDR_W)) u_cnt (
        .i_clk    (clk),
        .i_resetn (resetn),
        .i_clear  (w_cnt_clr),
        .i_enable (w_cnt_en),
        .o_count  (w_cnt),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        ram_wren    = 1'b0;
        ram_address = r_addr;
        ram_data    = r_data;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            IDLE: begin
                ram_address = addr_in;
                ram_data    = data_in;
                w_cnt_clr   = 1'b1;
                if (go) begin
                    case (op_e'(op))
                        OP_WRITE: w_next = WR;
                        OP_READ:  w_next = RD_ISSUE;
                        OP_FILL:  w_next = FILL;
                        OP_SUM:   w_next = SUM_RUN;
                    endcase
                end
            end
            WR: begin
                ram_wren = 1'b1;
                w_next   = DONE;
            end
            RD_ISSUE:  w_next = RD_CAP;
            RD_CAP:    w_next = DONE;
            FILL: begin
                ram_wren    = 1'b1;
                ram_address = w_cnt;
                w_cnt_en    = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            SUM_RUN: begin
                ram_address = w_cnt;
                w_cnt_en    = 1'b1;
                if (w_last) begin
                    w_next = SUM_DRAIN;
                end
            end
            SUM_DRAIN: w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    assign w_acc_next = r_acc + {{(SUM_W-DATA_W){1'b0}}, ram_q};

    // ram_q lags the issued address by one cycle, so the first SUM_RUN cycle has nothing to add yet.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_rd_data <= '0;
            r_acc     <= '0;
            r_sum     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_addr <= addr_in;
                        r_data <= data_in;
                        if (op_e'(op) == OP_SUM) begin
                            r_acc <= '0;
                        end
                    end
                end
                RD_CAP: r_rd_data <= ram_q;
                SUM_RUN: begin
                    if (w_cnt != '0) begin
                        r_acc <= w_acc_next;
                    end
                end
                SUM_DRAIN: begin
                    r_acc <= w_acc_next;
                    r_sum <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign rd_data = r_rd_data;
    assign sum     = r_sum;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Bench for ram_scan_ctrl with the RAM model attached; a transaction-level model predicts results and latencies.
module tb_ram_scan_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       go;
    logic [1:0] op;
    logic [4:0] addr_in;
    logic [3:0] data_in;
    logic       busy;
    logic       done;
    logic [3:0] rd_data;
    logic [8:0] sum;
    logic [4:0] ram_address;
    logic [3:0] ram_data;
    logic       ram_wren;
    logic [3:0] ram_q;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    logic [3:0] mdl_mem [32];
    logic [3:0] mdl_rd;
    logic [8:0] mdl_sum;
    int         mdl_lat;

    ram_scan_ctrl #(.ADDR_W(5), .DATA_W(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .go          (go),
        .op          (op),
        .addr_in     (addr_in),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .rd_data     (rd_data),
        .sum         (sum),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    ram32x4 #(.ADDR_W(5), .DATA_W(4)) u_ram (
        .clock   (clk),
        .address (ram_address),
        .data    (ram_data),
        .wren    (ram_wren),
        .q       (ram_q)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn && done) n_done++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: each command's effect on the array, and cycles from go acceptance to done.
    task automatic model_cmd(input logic [1:0] o, input logic [4:0] a, input logic [3:0] d);
        int s;
        case (o)
            2'b00: begin mdl_mem[a] = d; mdl_lat = 2; end
            2'b01: begin mdl_rd = mdl_mem[a]; mdl_lat = 3; end
            2'b10: begin
                for (int i = 0; i < 32; i++) mdl_mem[i] = d;
                mdl_lat = 33;
            end
            default: begin
                s = 0;
                for (int i = 0; i < 32; i++) s += int'(mdl_mem[i]);
                mdl_sum = 9'(s);
                mdl_lat = 34;
            end
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] o, input logic [4:0] a, input logic [3:0] d,
                           output int lat);
        @(negedge clk);
        go = 1'b1; op = o; addr_in = a; data_in = d;
        @(negedge clk);
        go = 1'b0;
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; go = 1'b0; op = 2'b00; addr_in = 5'd17; data_in = 4'h9;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_tests++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", ram_wren); end
        n_tests++; if (rd_data !== 4'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        n_tests++; if (sum !== 9'd0)     begin n_fail++; $display("FAIL reset_sum got %0d want 0", sum); end
        n_tests++; if (ram_address !== 5'd17 || ram_data !== 4'h9) begin
            n_fail++; $display("FAIL idle_transparent got %0d/%h want 17/9", ram_address, ram_data);
        end
        resetn = 1'b1;
    endtask

    task automatic test_fill_sum();
        int lat, d0;
        d0 = n_done;
        run_cmd(2'b10, 5'd0, 4'hA, lat); model_cmd(2'b10, 5'd0, 4'hA);
        n_tests++; if (lat != 33) begin n_fail++; $display("FAIL fill_latency got %0d want 33", lat); end
        run_cmd(2'b11, 5'd0, 4'h0, lat); model_cmd(2'b11, 5'd0, 4'h0);
        n_tests++; if (lat != 34) begin n_fail++; $display("FAIL sum_latency got %0d want 34", lat); end
        n_tests++; if (sum !== 9'd320) begin n_fail++; $display("FAIL sum_fill_a got %0d want 320", sum); end
        @(negedge clk);
        n_tests++; if (n_done - d0 != 2) begin n_fail++; $display("FAIL done_pulses got %0d want 2", n_done - d0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done got %b want 0", busy); end
    endtask

    task automatic test_write_read();
        int lat;
        run_cmd(2'b00, 5'd5, 4'h3, lat); model_cmd(2'b00, 5'd5, 4'h3);
        n_tests++; if (lat != 2) begin n_fail++; $display("FAIL write_latency got %0d want 2", lat); end
        run_cmd(2'b01, 5'd5, 4'h0, lat); model_cmd(2'b01, 5'd5, 4'h0);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL read_latency got %0d want 3", lat); end
        n_tests++; if (rd_data !== 4'h3) begin n_fail++; $display("FAIL read_addr5 got %h want 3", rd_data); end
        run_cmd(2'b01, 5'd6, 4'h0, lat); model_cmd(2'b01, 5'd6, 4'h0);
        n_tests++; if (rd_data !== 4'hA) begin n_fail++; $display("FAIL read_addr6 got %h want a", rd_data); end
    endtask

    task automatic test_fill_max();
        int lat;
        run_cmd(2'b10, 5'd0, 4'hF, lat); model_cmd(2'b10, 5'd0, 4'hF);
        run_cmd(2'b11, 5'd0, 4'h0, lat); model_cmd(2'b11, 5'd0, 4'h0);
        n_tests++; if (sum !== 9'd480) begin n_fail++; $display("FAIL sum_fill_f got %0d want 480", sum); end
    endtask

    task automatic test_go_ignored();
        int  lat;
        bit  wr_seen;
        @(negedge clk);
        go = 1'b1; op = 2'b11; addr_in = 5'd0; data_in = 4'h0;
        @(negedge clk);
        go = 1'b0; lat = 1; wr_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ram_wren) wr_seen = 1'b1;
            if (done) break;
            if (lat == 5) begin go = 1'b1; op = 2'b00; addr_in = 5'd3; data_in = 4'h0; end
            if (lat == 6) go = 1'b0;
            @(negedge clk);
            lat++;
        end
        model_cmd(2'b11, 5'd0, 4'h0);
        n_tests++; if (wr_seen) begin n_fail++; $display("FAIL go_ignored_wren got 1 want 0"); end
        n_tests++; if (lat != mdl_lat) begin n_fail++; $display("FAIL go_ignored_latency got %0d want %0d", lat, mdl_lat); end
        n_tests++; if (sum !== mdl_sum) begin n_fail++; $display("FAIL go_ignored_sum got %0d want %0d", sum, mdl_sum); end
        run_cmd(2'b01, 5'd3, 4'h0, lat); model_cmd(2'b01, 5'd3, 4'h0);
        n_tests++; if (rd_data !== mdl_rd) begin n_fail++; $display("FAIL go_ignored_mem got %h want %h", rd_data, mdl_rd); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] a;
        int bad, pulses;
        a = 5'($urandom_range(0, 31));
        model_cmd(2'b00, a, 4'h6);
        begin int lat; run_cmd(2'b00, a, 4'h6, lat); end
        @(negedge clk);
        go = 1'b1; op = 2'b01; addr_in = a;
        bad = 0; pulses = 0;
        // Each READ occupies 3 busy cycles followed by one IDLE cycle where go is re-accepted.
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) pulses++;
            if (done !== ((c % 4) == 3) || busy !== ((c % 4) != 0)) bad++;
        end
        go = 1'b0;
        model_cmd(2'b01, a, 4'h0);
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL b2b_pattern got %0d bad cycles want 0", bad); end
        n_tests++; if (pulses != 5) begin n_fail++; $display("FAIL b2b_pulses got %0d want 5", pulses); end
        n_tests++; if (rd_data !== mdl_rd) begin n_fail++; $display("FAIL b2b_rd_data got %h want %h", rd_data, mdl_rd); end
    endtask

    task automatic test_reset_abort();
        int  lat;
        bit  found;
        run_cmd(2'b10, 5'd0, 4'h0, lat); model_cmd(2'b10, 5'd0, 4'h0);
        run_cmd(2'b01, 5'd2, 4'h0, lat);
        @(negedge clk);
        go = 1'b1; op = 2'b10; data_in = 4'h1;
        @(negedge clk);
        go = 1'b0; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ram_wren && ram_address == 5'd10) begin found = 1'b1; break; end
            @(negedge clk);
        end
        resetn = 1'b0;
        #1;
        n_tests++; if (!found) begin n_fail++; $display("FAIL abort_count10 got not_seen want seen"); end
        n_tests++; if ({busy, done, ram_wren} !== 3'b000) begin
            n_fail++; $display("FAIL abort_ctrl got %b want 000", {busy, done, ram_wren});
        end
        n_tests++; if (rd_data !== 4'h0 || sum !== 9'd0) begin
            n_fail++; $display("FAIL abort_results got %h/%0d want 0/0", rd_data, sum);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) mdl_mem[i] = 4'h1;
        mdl_rd = 4'h0; mdl_sum = 9'd0;
        run_cmd(2'b11, 5'd0, 4'h0, lat); model_cmd(2'b11, 5'd0, 4'h0);
        n_tests++; if (sum !== 9'd10) begin n_fail++; $display("FAIL abort_sum got %0d want 10", sum); end
    endtask

    task automatic test_random();
        logic [1:0] o;
        logic [4:0] a;
        logic [3:0] d;
        int lat;
        for (int k = 0; k < 30; k++) begin
            o = 2'($urandom_range(0, 3));
            a = 5'($urandom_range(0, 31));
            d = 4'($urandom_range(0, 15));
            run_cmd(o, a, d, lat);
            model_cmd(o, a, d);
            n_tests++; if (lat != mdl_lat) begin n_fail++; $display("FAIL rand_latency[%0d] op %0d got %0d want %0d", k, o, lat, mdl_lat); end
            n_tests++; if (rd_data !== mdl_rd) begin n_fail++; $display("FAIL rand_rd_data[%0d] got %h want %h", k, rd_data, mdl_rd); end
            n_tests++; if (sum !== mdl_sum) begin n_fail++; $display("FAIL rand_sum[%0d] got %0d want %0d", k, sum, mdl_sum); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl_mem[i] = 4'h0;
        mdl_rd = 4'h0; mdl_sum = 9'd0; mdl_lat = 0;
        test_reset();
        test_fill_sum();
        test_write_read();
        test_fill_max();
        test_go_ignored();
        test_back_to_back();
        test_reset_abort();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_scan_ctrl.md
RAM_SCAN_CTRL -- requirements
Module: ram_scan_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5: RAM address width (32 words).
REQ-002 Parameter DATA_W, default 4: RAM word width.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 Port go, input, 1: command strobe, sampled only in IDLE.
REQ-006 Port op, input, 2: command; 00 WRITE, 01 READ, 10 FILL, 11 SUM.
REQ-007 Port addr_in, input, ADDR_W: target address for WRITE and READ.
REQ-008 Port data_in, input, DATA_W: write value for WRITE and FILL.
REQ-009 Port busy, output, 1: high from the cycle after go acceptance until the DONE state is left.
REQ-010 Port done, output, 1: one-cycle completion pulse.
REQ-011 Port rd_data, output, DATA_W: last READ result, held.
REQ-012 Port sum, output, 9: last SUM result (max 32*15=480), held.
REQ-013 Ports ram_address (output, ADDR_W), ram_data (output, DATA_W), ram_wren (output, 1), ram_q (input, DATA_W): drive ram32x4; the RAM registers address/data/wren, and q is valid one cycle after the address edge.

Function
REQ-014 States SHALL be IDLE, WR, RD_ISSUE, RD_CAP, FILL, SUM_RUN, SUM_DRAIN, DONE.
REQ-015 In IDLE with go=1, op, addr_in and data_in SHALL be latched and the FSM SHALL move to WR, RD_ISSUE, FILL or SUM_RUN per op.
REQ-016 go SHALL be ignored in every state except IDLE; a held-high go SHALL start one new command per return to IDLE.
REQ-017 WR: ram_wren=1, ram_address=latched addr, ram_data=latched data for exactly one cycle, then DONE.
REQ-018 RD_ISSUE drives latched addr with ram_wren=0, then RD_CAP loads rd_data<=ram_q, then DONE; done follows go by 3 cycles.
REQ-019 FILL: a 5-bit counter starts at 0; ram_wren=1 for 32 consecutive cycles at addresses 0..31 with latched data; after address 31 it moves to DONE. No wrap to 0 is written twice.
REQ-020 SUM_RUN: addresses 0..31 are issued one per cycle with ram_wren=0; from the second cycle onward the accumulator adds the previous address's ram_q, zero-extended to 9 bits.
REQ-021 SUM_DRAIN SHALL add the ram_q of address 31, then copy the accumulator to sum; the accumulator SHALL clear on SUM entry.
REQ-022 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-023 In IDLE: ram_wren=0, ram_address=addr_in, ram_data=data_in (transparent, for manual browsing).
REQ-024 ram_wren SHALL be 0 in every state except WR and FILL.

Reset
REQ-025 resetn=0 SHALL immediately force IDLE, counter=0, accumulator=0, busy=0, done=0, ram_wren=0, rd_data=0, sum=0, regardless of the operation in progress.
REQ-026 RAM contents SHALL NOT be cleared by reset; a FILL aborted by reset leaves a partially written RAM.

Structure
REQ-027 Package ram_ctrl_pkg SHALL hold the op encodings, the state encoding and the ADDR_W/DATA_W/SUM_W constants.
REQ-028 One sub-module, ram_addr_counter (clear, enable, 5-bit count, last flag at 31), SHALL be shared by FILL and SUM.
REQ-029 ram32x4 SHALL be instantiated in the bench or top, not inside ram_scan_ctrl.

Verification
REQ-030 FILL with data_in=4'hA, then SUM: sum=9'd320; done pulses once per command; the FILL done comes 33 cycles after go.
REQ-031 WRITE addr 5 = 4'h3, then READ addr 5: rd_data=4'h3; READ addr 6 after FILL 4'hA gives 4'hA.
REQ-032 FILL 4'hF, then SUM: sum=9'd480, with no overflow.
REQ-033 Assert resetn=0 at FILL count 10 after a prior FILL 4'h0, then SUM with data 4'h1 filled at addresses 0..9: sum=9'd10, and all outputs read 0 during reset.
REQ-034 Pulse go during SUM_RUN with op=00: no write occurs (ram_wren stays 0) and sum is unaffected.
REQ-035 Hold go=1 continuously with op=01: back-to-back READs, each with a one-cycle done pulse and one IDLE cycle between them.
